mem_multiport_segwr: RTL
========================

Name: mem_multiport_segwr

Overview:
- Parametrised word memory: one segment-write port, NUM_RD registered read ports with per-port enable.
- Writes update a SEG_W-bit part-select of one word at a dynamic bit base (mem[addr][base +: SEG_W]).
- Built-in clear engine zeroes the whole array, one word per cycle, on request.
- Configurable read-during-write (RDW) semantics.
- Generalises the single-port comb/seq/masked/part-select memory blocks used in the conversion flow.

Parameters:
- DATA_W, 8, word width in bits (>=2)
- DEPTH, 16, number of words (>=2)
- ADDR_W, $clog2(DEPTH), address width
- BASE_W, $clog2(DATA_W), width of the write bit-base
- SEG_W, 4, bits written per write (1..DATA_W)
- NUM_RD, 2, number of read ports (1..8)
- RDW_NEW, 0, 0 = same-cycle read returns old word; 1 = returns merged new word

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write word address
- wr_base  in  BASE_W  LSB index of written segment
- wr_data  in  SEG_W  segment data
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port i at [i*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  per-port data-valid
- clr_start  in  1  pulse: start clear sweep
- busy  out  1  clear sweep in progress
- wr_drop  out  1  one-cycle pulse: write discarded
- wr_trunc  out  1  one-cycle pulse: segment partially out of word range

Behaviour:
- Reset (async assert, sync-released use):
  - rd_data = 0, rd_valid = 0, busy = 0, wr_drop = 0, wr_trunc = 0.
  - FSM = IDLE, clear counter = 0.
  - Array contents are not reset.
- Write (IDLE, wr_en=1, wr_addr < DEPTH):
  - At the edge, bits wr_base .. wr_base+SEG_W-1 of the word are replaced by wr_data; other bits are unchanged.
  - Bits with index >= DATA_W are discarded.
  - If any bit is discarded, wr_trunc pulses the following cycle.
- wr_addr >= DEPTH: write discarded, wr_drop pulses next cycle, array unchanged.
- Read (port i, rd_en[i]=1):
  - Latency 1: rd_data_i = mem[rd_addr_i] and rd_valid[i] = 1 on the next cycle.
  - rd_addr_i >= DEPTH returns 0 with valid = 1.
- rd_en[i] = 0: rd_valid[i] = 0 next cycle; rd_data_i holds its last value.
- Multiple ports may read the same address in the same cycle; all return identical data.
- RDW, same address read and written in the same cycle:
  - RDW_NEW = 0: return the pre-write word.
  - RDW_NEW = 1: return the word with the segment merged (truncation applied).
- FSM:
  - IDLE -> CLEAR on clr_start = 1; counter = 0, busy = 1 from the next cycle.
  - CLEAR: each cycle write all-zero to mem[counter], counter++.
  - When counter = DEPTH-1 that word is zeroed, then -> IDLE; busy = 0 the following cycle.
  - Total busy cycles = DEPTH.
  - clr_start while in CLEAR is ignored; the sweep does not restart.
- During CLEAR:
  - Any wr_en = 1 is discarded and wr_drop pulses.
  - Reads proceed normally.
  - A read of the address cleared that same cycle follows RDW_NEW: 0 gives old word, 1 gives 0.
- Simultaneous clr_start and wr_en in IDLE: the write is performed that cycle; the sweep starts next cycle (and later zeroes that word).
- Reset asserted mid-sweep: FSM -> IDLE, busy = 0; words already cleared stay 0, the rest are unchanged.

Decomposition:
- Package mem_port_pkg:
  - clr_state_e enum {IDLE, CLEAR}.
  - Function seg_mask(base, SEG_W, DATA_W) returning a DATA_W-bit mask.
  - Function seg_trunc(base) flagging any bit >= DATA_W.
- Sub-module mem_rd_port: one registered read port, instantiated NUM_RD times via generate.
  - Inputs: en, addr, array word, bypass word, bypass-hit.
  - Outputs: data, valid.

Test Plan:
- Reset, write addr 3 base 0 data 4'hA, then base 4 data 4'h5; read port0 addr 3 -> 8'h5A one cycle after rd_en, rd_valid = 1 for exactly that cycle.
- Write base 6 data 4'hF on a zeroed word -> word = 8'hC0, wr_trunc pulses once.
- RDW_NEW = 0 and RDW_NEW = 1 benches: mem[5] = 8'h11, same cycle write base 0 data 4'h7 and read addr 5 -> 8'h11 / 8'h17; next-cycle read -> 8'h17 for both.
- Write wr_addr = DEPTH (DEPTH = 12, ADDR_W = 4, addr 12) -> wr_drop pulse, no array change; read addr 12 -> 0 with valid.
- Fill all words with 8'hFF, pulse clr_start -> busy high exactly 16 cycles, write during sweep -> wr_drop, then all 16 words read 0 on both ports.
- Assert rst_n = 0 after 5 sweep cycles -> busy = 0 and rd_valid = 0 immediately (async); afterwards words 0..4 read 0, words 5..15 read 8'hFF.

Source files
------------

// File: rtl/mem_port_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_port_pkg : clear-FSM state type and segment mask/truncation helpers |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
package mem_port_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Callers size-cast the result down to their own word width.
  function automatic logic [MAX_W-1:0] seg_mask(input int base, input int seg_w, input int data_w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++)
      m[i] = (i >= base) && (i < base + seg_w) && (i < data_w);
    return m;
  endfunction

  function automatic logic seg_trunc(input int base, input int seg_w, input int data_w);
    return (base + seg_w) > data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_multiport_segwr_rd_port.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_rd_port : one registered read port with optional write bypass      |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module mem_rd_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] byp_word,
  input  logic              byp_hit,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        if ({1'b0, addr} >= DEPTH_V)
          data <= '0;
        else if (byp_hit)
          data <= byp_word;
        else
          data <= word;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_multiport_segwr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_multiport_segwr : segment-write memory, N read ports, clear engine |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module mem_multiport_segwr
  import mem_port_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int BASE_W  = $clog2(DATA_W),
  parameter int SEG_W   = 4,
  parameter int NUM_RD  = 2,
  parameter int RDW_NEW = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [BASE_W-1:0]        wr_base,
  input  logic [SEG_W-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr_start,
  output logic                     busy,
  output logic                     wr_drop,
  output logic                     wr_trunc
);

  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  logic [DATA_W-1:0] mem [DEPTH];
  clr_state_e        state;
  logic [ADDR_W-1:0] clr_cnt;

  logic              wr_in_range;
  logic              wr_ok;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] merged;
  logic              port_we;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_word;

  // Single array write port, shared by the clear sweep and user writes.
  always_comb begin
    wr_in_range = {1'b0, wr_addr} < DEPTH_V;
    wr_ok       = (state == IDLE) && wr_en && wr_in_range;
    mask        = DATA_W'(seg_mask(int'(wr_base), SEG_W, DATA_W));
    data_sh     = DATA_W'(MAX_W'(wr_data) << wr_base);
    merged      = wr_in_range ? ((mem[wr_addr] & ~mask) | (data_sh & mask)) : '0;
    port_we     = (state == CLEAR) || wr_ok;
    port_addr   = (state == CLEAR) ? clr_cnt : wr_addr;
    port_word   = (state == CLEAR) ? '0 : merged;
  end

  always_ff @(posedge clk) begin
    if (port_we)
      mem[port_addr] <= port_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      busy     <= 1'b0;
      wr_drop  <= 1'b0;
      wr_trunc <= 1'b0;
    end else begin
      wr_drop  <= wr_en && ((state == CLEAR) || !wr_in_range);
      wr_trunc <= wr_ok && seg_trunc(int'(wr_base), SEG_W, DATA_W);
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr_g;
    logic              hit_g;

    assign addr_g = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit_g  = (RDW_NEW != 0) && port_we && (addr_g == port_addr);

    mem_rd_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (rd_en[g]),
      .addr     (addr_g),
      .word     (mem[addr_g]),
      .byp_word (port_word),
      .byp_hit  (hit_g),
      .data     (rd_data[g*DATA_W +: DATA_W]),
      .valid    (rd_valid[g])
    );
  end

endmodule
`default_nettype wire
